// File: rtl/marquee_pkg.sv
// Shared types and helpers for the scrolling-marquee character feeder.
package marquee_pkg;

  localparam logic [7:0] ASCII_SPACE = 8'h20;

  typedef enum logic [0:0] {
    StBlank,
    StDrive
  } slot_state_e;

  // Width needed to hold a count of 0..depth inclusive.
  function automatic int unsigned len_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/marquee_scan_timer.sv
// Digit-slot timing: slot counter, BLANK/DRIVE FSM, digit index, frame pulse and
// scroll-step divider. digit_o/drive_o give the values for the coming cycle.
module marquee_scan_timer
  import marquee_pkg::*;
#(
  parameter int unsigned DIGITS     = 4,
  parameter int unsigned SCAN_DIV   = 1000,
  parameter int unsigned BLANK      = 50,
  parameter int unsigned SCROLL_DIV = 250,
  localparam int unsigned DigW      = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  output logic [DigW-1:0] digit_o,
  output logic            drive_o,
  output logic            frame_o,
  output logic            scroll_step_o
);

  localparam int unsigned SlotW = $clog2(SCAN_DIV);
  localparam int unsigned FrmW  = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

  logic [SlotW-1:0] slot_q, slot_d;
  logic [DigW-1:0]  digit_q, digit_d;
  logic [FrmW-1:0]  fcnt_q, fcnt_d;
  slot_state_e      state_q, state_d;
  logic             slot_end;

  always_comb begin
    slot_end = (slot_q == SlotW'(SCAN_DIV - 1));
    slot_d   = slot_end ? '0 : slot_q + SlotW'(1);

    digit_d = digit_q;
    if (slot_end) begin
      digit_d = (digit_q == DigW'(DIGITS - 1)) ? '0 : digit_q + DigW'(1);
    end

    frame_o       = slot_end && (digit_q == DigW'(DIGITS - 1));
    scroll_step_o = frame_o && (fcnt_q == FrmW'(SCROLL_DIV - 1));

    fcnt_d = fcnt_q;
    if (frame_o) begin
      fcnt_d = scroll_step_o ? '0 : fcnt_q + FrmW'(1);
    end

    state_d = state_q;
    unique case (state_q)
      StBlank: if (slot_d >= SlotW'(BLANK)) state_d = StDrive;
      StDrive: if (slot_end && (BLANK != 0)) state_d = StBlank;
      default: state_d = StBlank;
    endcase

    digit_o = digit_d;
    drive_o = (state_d == StDrive);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot_q  <= '0;
      digit_q <= '0;
      fcnt_q  <= '0;
      state_q <= StBlank;
    end else begin
      slot_q  <= slot_d;
      digit_q <= digit_d;
      fcnt_q  <= fcnt_d;
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/marquee_scroller.sv
// Message buffer, scroll offset and registered character/digit-select outputs feeding
// the 16-segment ROM.
module marquee_scroller
  import marquee_pkg::*;
#(
  parameter int unsigned MSG_DEPTH  = 32,
  parameter int unsigned DIGITS     = 4,
  parameter int unsigned SCAN_DIV   = 1000,
  parameter int unsigned BLANK      = 50,
  parameter int unsigned SCROLL_DIV = 250,
  localparam int unsigned LenW      = len_width(MSG_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  output logic              wr_ready,
  input  logic              clear,
  input  logic              run,
  output logic [7:0]        ascii,
  output logic [DIGITS-1:0] digit_sel,
  output logic [LenW-1:0]   msg_len,
  output logic              frame
);

  localparam int unsigned AddrW = $clog2(MSG_DEPTH);
  localparam int unsigned OffW  = $clog2(MSG_DEPTH + DIGITS + 1);
  localparam int unsigned IdxW  = OffW + 1;
  localparam int unsigned DigW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [7:0]        msg_buf_q [MSG_DEPTH];
  logic [7:0]        msg_buf_d [MSG_DEPTH];
  logic [LenW-1:0]   len_q, len_d;
  logic [OffW-1:0]   offset_q, offset_d;
  logic [OffW-1:0]   vlen_q, vlen_d;
  logic [IdxW-1:0]   idx_raw, idx;
  logic [7:0]        ascii_q, ascii_d;
  logic [DIGITS-1:0] sel_q, sel_d;
  logic              wr_accept;

  logic [DigW-1:0]   digit_nxt;
  logic              drive_nxt;
  logic              scroll_step;

  marquee_scan_timer #(
    .DIGITS     (DIGITS),
    .SCAN_DIV   (SCAN_DIV),
    .BLANK      (BLANK),
    .SCROLL_DIV (SCROLL_DIV)
  ) u_scan_timer (
    .clk_i         (clk),
    .rst_i         (rst),
    .digit_o       (digit_nxt),
    .drive_o       (drive_nxt),
    .frame_o       (frame),
    .scroll_step_o (scroll_step)
  );

  always_comb begin
    wr_accept = wr_en && !clear && (len_q < LenW'(MSG_DEPTH));

    msg_buf_d = msg_buf_q;
    if (wr_accept) msg_buf_d[len_q[AddrW-1:0]] = wr_data;

    len_d = len_q;
    if (clear) begin
      len_d = '0;
    end else if (wr_accept) begin
      len_d = len_q + LenW'(1);
    end

    // Wrap point uses the length registered before this cycle.
    vlen_q   = OffW'(len_q) + OffW'(DIGITS);
    offset_d = offset_q;
    if (clear) begin
      offset_d = '0;
    end else if (scroll_step && run && (len_q != '0)) begin
      offset_d = (offset_q == vlen_q - OffW'(1)) ? '0 : offset_q + OffW'(1);
    end

    // Outputs are built from next-state values so the char and select land together
    // and a fresh write is visible on the very next drive cycle.
    vlen_d  = OffW'(len_d) + OffW'(DIGITS);
    idx_raw = IdxW'(offset_d) + IdxW'(digit_nxt);
    idx     = (idx_raw >= IdxW'(vlen_d)) ? idx_raw - IdxW'(vlen_d) : idx_raw;

    ascii_d = ASCII_SPACE;
    sel_d   = '1;
    if (drive_nxt) begin
      sel_d = ~(DIGITS'(1) << digit_nxt);
      if (idx < IdxW'(len_d)) ascii_d = msg_buf_d[idx[AddrW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q    <= '0;
      offset_q <= '0;
      ascii_q  <= ASCII_SPACE;
      sel_q    <= '1;
    end else begin
      len_q    <= len_d;
      offset_q <= offset_d;
      ascii_q  <= ascii_d;
      sel_q    <= sel_d;
    end
  end

  // Contents beyond msg_len are never read, so the buffer needs no reset.
  always_ff @(posedge clk) begin
    msg_buf_q <= msg_buf_d;
  end

  assign ascii     = ascii_q;
  assign digit_sel = sel_q;
  assign msg_len   = len_q;
  assign wr_ready  = (len_q < LenW'(MSG_DEPTH));

endmodule

// File: tb/tb_marquee_scroller.sv
// Directed bench for marquee_scroller with small timing parameters.
module tb_marquee_scroller;

  localparam int unsigned MSG_DEPTH  = 8;
  localparam int unsigned DIGITS     = 4;
  localparam int unsigned SCAN_DIV   = 4;
  localparam int unsigned BLANK      = 1;
  localparam int unsigned SCROLL_DIV = 2;

  logic       clk = 1'b0;
  logic       rst, wr_en, clear, run;
  logic [7:0] wr_data, ascii;
  logic [3:0] digit_sel;
  logic [3:0] msg_len;
  logic       wr_ready, frame;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [3:0] sel_log [16];
  logic [7:0] asc_log [16];
  logic       frm_log [16];

  marquee_scroller #(
    .MSG_DEPTH  (MSG_DEPTH),
    .DIGITS     (DIGITS),
    .SCAN_DIV   (SCAN_DIV),
    .BLANK      (BLANK),
    .SCROLL_DIV (SCROLL_DIV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .clear     (clear),
    .run       (run),
    .ascii     (ascii),
    .digit_sel (digit_sel),
    .msg_len   (msg_len),
    .frame     (frame)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic record_frame();
    for (int c = 0; c < 16; c++) begin
      sel_log[c] = digit_sel;
      asc_log[c] = ascii;
      frm_log[c] = frame;
      tick();
    end
  endtask

  task automatic align_frame();
    while (cyc % 16 != 0) tick();
  endtask

  task automatic write_byte(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    tick();
    wr_en   = 1'b0;
  endtask

  // Slot c/4 is digit c/4; the first cycle of each slot is blanked.
  function automatic logic [3:0] want_sel(input int c);
    logic [3:0] one;
    one = 4'b0001;
    return (c % 4 == 0) ? 4'hF : ~(one << (c / 4));
  endfunction

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b0; clear = 1'b0; run = 1'b0; wr_data = 8'h00;
    tick();
    tick();
    checks++;
    if (digit_sel !== 4'hF || ascii !== 8'h20 || wr_ready !== 1'b1 || msg_len !== 4'd0
        || frame !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: sel=%b ascii=%h rdy=%b len=%0d frame=%b, want 1111 20 1 0 0",
               digit_sel, ascii, wr_ready, msg_len, frame);
    end
    rst = 1'b0;
    cyc = 0;
    record_frame();
    for (int c = 0; c < 16; c++) begin
      checks++;
      if (sel_log[c] !== want_sel(c) || asc_log[c] !== 8'h20 || frm_log[c] !== (c == 15)) begin
        errors++;
        $display("FAIL idle_frame cyc %0d: sel=%b ascii=%h frame=%b, want sel=%b ascii=20 frame=%b",
                 c, sel_log[c], asc_log[c], frm_log[c], want_sel(c), (c == 15));
      end
    end
  endtask

  task automatic test_write_hi();
    string want;
    want = "HI  ";
    run = 1'b0;
    write_byte("H");
    write_byte("I");
    checks++;
    if (msg_len !== 4'd2 || wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL hi_len: len=%0d rdy=%b, want 2 1", msg_len, wr_ready);
    end
    align_frame();
    for (int f = 0; f < 2; f++) begin
      record_frame();
      for (int c = 0; c < 16; c++) begin
        checks++;
        if (sel_log[c] !== want_sel(c) || (c % 4 != 0 && asc_log[c] !== want[c/4])) begin
          errors++;
          $display("FAIL hi_frame f%0d cyc %0d: sel=%b ascii=%h, want sel=%b ascii=%h",
                   f, c, sel_log[c], asc_log[c], want_sel(c), want[c/4]);
        end
      end
    end
  endtask

  task automatic test_scroll();
    string tbl [9];
    string want;
    tbl = '{"HI  ", "I   ", "    ", "   H", "  HI", " HI ", "HI  ", "I   ", "    "};
    run = 1'b1;
    for (int s = 0; s < 9; s++) begin
      want = tbl[s];
      for (int f = 0; f < 2; f++) begin
        record_frame();
        for (int c = 1; c < 16; c += 2) begin
          checks++;
          if (asc_log[c] !== want[c/4] || sel_log[c] !== want_sel(c)) begin
            errors++;
            $display("FAIL scroll step %0d f%0d cyc %0d: sel=%b ascii=%h, want sel=%b ascii=%h",
                     s, f, c, sel_log[c], asc_log[c], want_sel(c), want[c/4]);
          end
        end
      end
    end
    run = 1'b0;
  endtask

  task automatic test_full_and_clear();
    string want;
    want = "BCDE";
    for (int i = 0; i < 6; i++) write_byte(8'h41 + 8'(i));
    checks++;
    if (msg_len !== 4'd8 || wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_len: len=%0d rdy=%b, want 8 0", msg_len, wr_ready);
    end
    write_byte("X");
    checks++;
    if (msg_len !== 4'd8 || wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_drop: len=%0d rdy=%b, want 8 0", msg_len, wr_ready);
    end
    align_frame();
    record_frame();
    for (int c = 1; c < 16; c++) begin
      if (c % 4 == 0) continue;
      checks++;
      if (asc_log[c] !== want[c/4]) begin
        errors++;
        $display("FAIL full_frame cyc %0d: ascii=%h, want %h", c, asc_log[c], want[c/4]);
      end
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++;
    if (msg_len !== 4'd0 || wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL clear_len: len=%0d rdy=%b, want 0 1", msg_len, wr_ready);
    end
    write_byte("H");
    write_byte("I");
    want = "HI  ";
    align_frame();
    record_frame();
    for (int c = 1; c < 16; c++) begin
      if (c % 4 == 0) continue;
      checks++;
      if (asc_log[c] !== want[c/4]) begin
        errors++;
        $display("FAIL clear_offset cyc %0d: ascii=%h, want %h", c, asc_log[c], want[c/4]);
      end
    end
  endtask

  task automatic test_clear_write();
    string want;
    want = "HI  ";
    clear = 1'b1; wr_en = 1'b1; wr_data = "Z";
    tick();
    clear = 1'b0; wr_en = 1'b0;
    checks++;
    if (msg_len !== 4'd0) begin
      errors++;
      $display("FAIL clear_wins: len=%0d, want 0", msg_len);
    end
    align_frame();
    record_frame();
    for (int c = 0; c < 16; c++) begin
      checks++;
      if (asc_log[c] !== 8'h20) begin
        errors++;
        $display("FAIL clear_wins_frame cyc %0d: ascii=%h, want 20", c, asc_log[c]);
      end
    end
    run = 1'b1;
    for (int f = 0; f < 4; f++) record_frame();
    run = 1'b0;
    write_byte("H");
    write_byte("I");
    align_frame();
    record_frame();
    for (int c = 1; c < 16; c++) begin
      if (c % 4 == 0) continue;
      checks++;
      if (asc_log[c] !== want[c/4]) begin
        errors++;
        $display("FAIL empty_no_scroll cyc %0d: ascii=%h, want %h", c, asc_log[c], want[c/4]);
      end
    end
  endtask

  task automatic test_reset_mid();
    align_frame();
    tick();
    tick();
    checks++;
    if (digit_sel !== 4'b1110 || ascii !== "H") begin
      errors++;
      $display("FAIL pre_reset: sel=%b ascii=%h, want 1110 48", digit_sel, ascii);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (digit_sel !== 4'hF || ascii !== 8'h20 || msg_len !== 4'd0 || wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: sel=%b ascii=%h len=%0d rdy=%b, want 1111 20 0 1",
               digit_sel, ascii, msg_len, wr_ready);
    end
    rst = 1'b0;
    cyc = 0;
    checks++;
    if (digit_sel !== 4'hF) begin
      errors++;
      $display("FAIL post_reset_c0: sel=%b, want 1111", digit_sel);
    end
    tick();
    checks++;
    if (digit_sel !== 4'b1110 || ascii !== 8'h20) begin
      errors++;
      $display("FAIL post_reset_c1: sel=%b ascii=%h, want 1110 20", digit_sel, ascii);
    end
  endtask

  initial begin
    test_reset();
    test_write_hi();
    test_scroll();
    test_full_and_clear();
    test_clear_write();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
